sm4_stream_ctrl: RTL
====================

// Module: sm4_stream_ctrl
// PURPOSE
//  Initiator that drives the SM4 core (sm4_top): requests key expansion, then feeds it one 128-bit block at a time.
//  Accepts plaintext/ciphertext from an upstream valid/ready stream and returns core results on a downstream stream.
//  Sits between the DMA/stream fabric and the SM4 core. One block is in flight at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles to wait for key_exp_ready_in or ready_in before flagging error
//  TO_W            11    timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk                 in   1    clock
//  reset               in   1    synchronous, active-high reset
//  cfg_key             in   128  user key, sampled on key_load
//  cfg_decrypt         in   1    0=encrypt 1=decrypt, sampled on key_load
//  cfg_iv              in   128  CBC IV, sampled on key_load (ignored without SM4_CBC_EN)
//  key_load            in   1    1-cycle pulse: start key expansion (honoured only in IDLE/READY)
//  key_ready           out  1    key expanded, core usable
//  busy                out  1    state != IDLE && state != READY
//  err_timeout         out  1    sticky; cleared by reset or next accepted key_load
//  s_valid/s_ready     in/out 1  upstream handshake
//  s_data              in   128  input block
//  s_last              in   1    last block of message (passed through to m_last)
//  m_valid/m_ready     out/in 1  downstream handshake
//  m_data              out  128  result block
//  m_last              out  1    copy of s_last of the same block
//  sm4_enable_out      out  1    to core sm4_enable_in; high whenever state != IDLE
//  encdec_enable_out   out  1    to core encdec_enable_in; high in READY..OUT
//  encdec_sel_out      out  1    to core encdec_sel_in; registered cfg_decrypt
//  enable_key_exp_out  out  1    to core enable_key_exp_in; high in KEY_REQ/KEY_WAIT
//  user_key_valid_out  out  1    to core user_key_valid_in; 1-cycle pulse in KEY_REQ
//  user_key_out        out  128  to core user_key_in; registered cfg_key
//  valid_out           out  1    to core valid_in; 1-cycle pulse in ISSUE
//  data_out            out  128  to core data_in; held stable from ISSUE until OUT
//  key_exp_ready_in    in   1    from core key_exp_ready_out (level)
//  ready_in            in   1    from core ready_out; result_in valid when high
//  result_in           in   128  from core result_out
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, key/iv/data registers 0, timeout counter 0.
//  FSM: IDLE -key_load-> KEY_REQ (1 cycle) -> KEY_WAIT -key_exp_ready_in-> READY
//       READY -s_valid&&s_ready-> ISSUE (1 cycle) -> WAIT_RES -ready_in-> OUT -m_ready-> READY.
//  key_load in READY restarts at KEY_REQ; key_ready drops to 0 same edge. key_load in other states ignored.
//  s_ready = (state==READY) && !key_load; key_load wins over a simultaneous s_valid.
//  Input latch: s_data, s_last captured on s_valid&&s_ready edge; valid_out pulses the following cycle.
//  WAIT_RES: result_in captured on first cycle ready_in=1; m_valid=1 the next cycle (OUT).
//  OUT: m_valid, m_data, m_last held stable until m_ready; m_ready sampled 1 -> READY next edge.
//  Throughput: min 4 cycles/block + core latency (ISSUE, WAIT_RES>=1, OUT, READY).
//  ready_in while not in WAIT_RES is ignored.
//  Timeout: counter clears on entry to KEY_WAIT/WAIT_RES, increments each waiting cycle;
//   reaching TIMEOUT_CYCLES -> err_timeout=1, state IDLE, key_ready=0, no m_valid for that block.
//  key_ready = 1 only in READY..OUT after successful expansion.
//  Reset asserted mid-operation aborts everything; an in-flight block is dropped, not output.
// CONFIGURATION
//  SM4_CBC_EN defined: CBC chaining. chain reg loaded with cfg_iv on key_load.
//   Encrypt: data_out = s_data ^ chain; chain <= result_in on capture; m_data = result_in.
//   Decrypt: data_out = s_data; m_data = result_in ^ chain; chain <= s_data on capture.
//   chain reloads cfg_iv after a block with m_last=1 leaves OUT.
//  SM4_CBC_EN undefined: ECB; data_out = s_data, m_data = result_in, cfg_iv ignored, no chain reg.
// TESTING
//  Key: cfg_key=0123456789abcdeffedcba9876543210, key_load, core model asserts key_exp_ready_in after 32 cycles
//   -> user_key_valid_out one pulse, key_ready=1 in cycle after, s_ready=1.
//  ECB encrypt: s_data=0123456789abcdeffedcba9876543210 with real sm4_top
//   -> m_data=681edf34d206965e86b3e94f536e4246, m_last follows s_last.
//  Backpressure: m_ready=0 for 10 cycles -> m_valid/m_data stable, s_ready=0 throughout; m_ready=1 -> next block accepted.
//  Timeout: core model never asserts ready_in -> err_timeout=1 exactly TIMEOUT_CYCLES after WAIT_RES entry, state IDLE.
//  Collisions: key_load and s_valid same cycle in READY -> key restarts, block not taken; sync reset in WAIT_RES -> all outputs 0 next edge.
//  SM4_CBC_EN: IV=0, two identical plaintext blocks encrypted -> ciphertexts differ; decrypt round-trip restores both blocks.

Source files
------------

// File: rtl/sm4_stream_ctrl.sv
// Stream-side controller for the SM4 core: runs key expansion, then moves one block at a time from s_* to m_*.
// Optional CBC chaining when SM4_CBC_EN is defined; default build is ECB.
module sm4_stream_ctrl #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] cfg_key,
   input  logic         cfg_decrypt,
   input  logic [127:0] cfg_iv,
   input  logic         key_load,
   output logic         key_ready,
   output logic         busy,
   output logic         err_timeout,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [127:0] s_data,
   input  logic         s_last,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic         m_last,
   output logic         sm4_enable_out,
   output logic         encdec_enable_out,
   output logic         encdec_sel_out,
   output logic         enable_key_exp_out,
   output logic         user_key_valid_out,
   output logic [127:0] user_key_out,
   output logic         valid_out,
   output logic [127:0] data_out,
   input  logic         key_exp_ready_in,
   input  logic         ready_in,
   input  logic [127:0] result_in
);

   typedef enum logic [2:0] {
      S_IDLE, S_KEY_REQ, S_KEY_WAIT, S_READY, S_ISSUE, S_WAIT_RES, S_OUT
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            err_q, err_d;
   logic [127:0]    key_q, data_q, res_q;
   logic [127:0]    data_d, res_d;
   logic            dec_q, last_q;
   logic            key_acc, blk_acc, res_cap, out_done;

   assign key_acc  = key_load && (state_q == S_IDLE || state_q == S_READY);
   assign s_ready  = (state_q == S_READY) && !key_load;
   assign blk_acc  = s_valid && s_ready;
   assign res_cap  = (state_q == S_WAIT_RES) && ready_in;
   assign out_done = (state_q == S_OUT) && m_ready;

   always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (key_load) begin
               state_d = S_KEY_REQ;
               err_d   = 1'b0;
            end
         end
         S_KEY_REQ: begin
            state_d  = S_KEY_WAIT;
            to_cnt_d = '0;
         end
         S_KEY_WAIT: begin
            if (key_exp_ready_in) begin
               state_d = S_READY;
            end else if (to_cnt_q == TO_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_READY: begin
            // key_load has priority over a block offered in the same cycle
            if (key_load) begin
               state_d = S_KEY_REQ;
               err_d   = 1'b0;
            end else if (s_valid) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d  = S_WAIT_RES;
            to_cnt_d = '0;
         end
         S_WAIT_RES: begin
            if (ready_in) begin
               state_d = S_OUT;
            end else if (to_cnt_q == TO_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_OUT: begin
            if (m_ready) state_d = S_READY;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end

`ifdef SM4_CBC_EN
   logic [127:0] iv_q, chain_q;

   always_comb begin
      data_d = s_data;
      res_d  = result_in;
      if (!dec_q) data_d = s_data ^ chain_q;
      else        res_d  = result_in ^ chain_q;
   end

   // In decrypt mode data_q holds the raw ciphertext, which is the next chain value
   always_ff @(posedge clk) begin
      if (reset) begin
         iv_q    <= '0;
         chain_q <= '0;
      end else if (key_acc) begin
         iv_q    <= cfg_iv;
         chain_q <= cfg_iv;
      end else if (res_cap) begin
         chain_q <= dec_q ? data_q : result_in;
      end else if (out_done && last_q) begin
         chain_q <= iv_q;
      end
   end
`else
   logic unused_iv;
   assign unused_iv = ^cfg_iv;

   always_comb begin
      data_d = s_data;
      res_d  = result_in;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         key_q  <= '0;
         dec_q  <= 1'b0;
         data_q <= '0;
         last_q <= 1'b0;
         res_q  <= '0;
      end else begin
         if (key_acc) begin
            key_q <= cfg_key;
            dec_q <= cfg_decrypt;
         end
         if (blk_acc) begin
            data_q <= data_d;
            last_q <= s_last;
         end
         if (res_cap) res_q <= res_d;
      end
   end

   assign key_ready          = (state_q == S_READY) || (state_q == S_ISSUE) ||
                               (state_q == S_WAIT_RES) || (state_q == S_OUT);
   assign busy               = (state_q != S_IDLE) && (state_q != S_READY);
   assign err_timeout        = err_q;
   assign m_valid            = (state_q == S_OUT);
   assign m_data             = res_q;
   assign m_last             = last_q;
   assign sm4_enable_out     = (state_q != S_IDLE);
   assign encdec_enable_out  = key_ready;
   assign encdec_sel_out     = dec_q;
   assign enable_key_exp_out = (state_q == S_KEY_REQ) || (state_q == S_KEY_WAIT);
   assign user_key_valid_out = (state_q == S_KEY_REQ);
   assign user_key_out       = key_q;
   assign valid_out          = (state_q == S_ISSUE);
   assign data_out           = data_q;

endmodule
